sdram_stage_monitor: RTL and testbench
======================================

# sdram_stage_monitor

Parametrised successor to the SDRAM controller's formal harness bookkeeping. It tracks every controller FSM state (`lft_state`) visited during one host operation and checks in-order stage coverage for the write and read windows. It detects completion, refresh interruption and timeouts, records a sticky error cause, and reports per-operation latency. It sits beside `sdram_controller` in both simulation benches and formal wrappers: the bench drives `op_start`, and the monitor's `bad`/`err_sticky` outputs feed assertions.

## Interface
- `STATE_W`, 5: width of `lft_state`.
- `N_STATES`, 32: event-vector length; must be ≤ 2^`STATE_W`.
- `WR_LO`, 24 / `WR_HI`, 27: inclusive write-stage window.
- `RD_LO`, 16 / `RD_HI`, 20: inclusive read-stage window.
- `RF_LO`, 1 / `RF_HI`, 4: inclusive refresh-stage window.
- `TIMEOUT`, 63: cycles in TRACK before a timeout error.
- `LAT_W`, 8: latency counter width; must satisfy 2^`LAT_W` > `TIMEOUT`.
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `op_start`, in, 1: request to begin tracking an operation.
- `op_type`, in, 2: `IDLE`=0, `WRITE`=1, `READ`=2, `REFR`=3.
- `lft_state`, in, `STATE_W`: controller's current FSM state index.
- `in_use`, out, 1: an operation is being tracked.
- `done`, out, 1: combinational completion pulse.
- `bad`, out, 1: combinational stage-order violation on the current events.
- `interrupted`, out, 1: sticky per operation; refresh was seen after the window's first stage.
- `err_sticky`, out, 1: latched error.
- `err_code`, out, 3: first error cause.
- `events`, out, `N_STATES`: visited-state vector.
- `last_latency`, out, `LAT_W`: cycles taken by the last completed operation.
- `op_count`, out, 16: completed operations; wraps modulo 2^16.

## Operation
- **FSM states:**
  - IDLE: `in_use`=0.
  - TRACK: `in_use`=1.
  - ERROR is not a separate state; `err_sticky` is orthogonal to the FSM.
- **IDLE→TRACK** on `op_start` when `op_type` ≠ `IDLE`.
  - Latch `op_type` into `cur_op` and clear `lat_ctr` to 1.
  - `op_start` with `op_type`=`IDLE` is ignored.
  - `op_start` while in TRACK is ignored.
- **In TRACK, when `done`=0, each cycle:**
  - Set `events[lft_state]`; an index ≥ `N_STATES` is discarded and raises `err_code` `RANGE`=3.
  - Increment `lat_ctr`.
- **Order rule for window [LO,HI] of `cur_op`:** `bad`=1 if some i in [LO,HI-1] has `events[i]`=0 while any of `events[HI:i+1]` is 1. `bad` is evaluated on registered `events` only.
- **Completion:** `done` = `in_use` && (all bits of the window of `cur_op` set, or `events[RF_HI]` set). `REFR` ops complete only via `events[RF_HI]`.
- **On `done`, at the same edge:**
  - Return to IDLE and clear `events`.
  - Load `last_latency` ← `lat_ctr`.
  - Increment `op_count`.
  - Clear `interrupted`.
- **`interrupted`:** sets when `events[LO]`=1, the window is incomplete, and any of `events[RF_HI:RF_LO]` is 1. It is informational and not an error.
- **Errors:** the first error latches `err_sticky`=1 and `err_code`. Later errors never overwrite it.
  - `ORDER`=1: `bad`.
  - `TIMEOUT`=2: `lat_ctr` = `TIMEOUT` with `done`=0. The FSM is forced to IDLE and `events` are cleared.
  - `RANGE`=3: out-of-range `lft_state`.
- **Same-cycle precedence:** `done` beats `TIMEOUT`. `ORDER` beats `RANGE` for `err_code`.
- **Counters:** all counter arithmetic is unsigned. `lat_ctr` saturates at 2^`LAT_W`-1.

## Timing
- **Reset values** (when `rst_n`=0 at an edge): all outputs 0, `cur_op`=`IDLE`, FSM=IDLE. Reset clears the sticky error and aborts any in-flight operation the same cycle.
- **`op_start` sampled at edge N:**
  - `in_use`=1 from cycle N+1.
  - The first `lft_state` is sampled at edge N+1 and is visible in `events` at N+2.
- **`done` latency:** asserts in the first cycle that the registered `events` make the window complete. `in_use` drops at that edge. A new `op_start` is accepted in the same cycle as `done`'s falling edge only if sampled in IDLE, so ops are back-to-back with one IDLE cycle minimum.
- **Error latch:** `err_sticky` rises one cycle after the causing condition.

## Structure
- Package `sdram_mon_pkg`:
  - op codes `IDLE`/`WRITE`/`READ`/`REFR`;
  - `err_code` enum `NONE`=0, `ORDER`=1, `TIMEOUT`=2, `RANGE`=3;
  - a default-window localparam set.
- Sub-module `window_order_check`, parameters LO, HI, instantiated once for the write window and once for the read window.
  - Inputs: `events`.
  - Outputs: `order_bad`, `complete`, `started`.
  - The top selects outputs by `cur_op`.

## Test plan
- **WRITE, in order:** `op_type`=1, `lft_state` 24,25,26,27 → `done` in the cycle after 27 is registered; `bad`=0; `last_latency`=5; `op_count`=1.
- **READ, out of order:** 16,18 → `bad`=1 when 18 is registered; next cycle `err_sticky`=1, `err_code`=1. A subsequent timeout leaves `err_code`=1.
- **Refresh interrupt:** READ with 16,17,2,3,4 → `interrupted`=1 after 2; `done` via `events[4]`; `err_sticky`=0.
- **Timeout:** WRITE with `lft_state` held at 0 → at `lat_ctr`=63, `err_code`=2; `in_use`=0 next cycle; `events`=0.
- **Reset mid-op:** `rst_n`=0 during TRACK with `events[24]`=1 → the next cycle has all outputs 0. Also: `op_start` while `in_use`=1 is ignored, and `op_type`=0 is ignored.
- **Parameter sweep:** `STATE_W`=4, `N_STATES`=12, `lft_state`=13 → `err_code`=3.

Source files
------------

// File: rtl/sdram_stage_monitor_pkg.sv
// sdram_mon_pkg: op codes, error causes and default stage windows shared by the
// SDRAM stage monitor, its interface and its window checker.
package sdram_mon_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2, REFR = 2'd3} op_t;
   typedef enum logic [2:0] {ERR_NONE = 3'd0, ERR_ORDER = 3'd1, ERR_TIMEOUT = 3'd2, ERR_RANGE = 3'd3} err_t;
   typedef enum logic {S_IDLE = 1'b0, S_TRACK = 1'b1} mon_state_t;
   localparam int DEF_STATE_W  = 5;
   localparam int DEF_N_STATES = 32;
   localparam int DEF_WR_LO    = 24;
   localparam int DEF_WR_HI    = 27;
   localparam int DEF_RD_LO    = 16;
   localparam int DEF_RD_HI    = 20;
   localparam int DEF_RF_LO    = 1;
   localparam int DEF_RF_HI    = 4;
   localparam int DEF_TIMEOUT  = 63;
   localparam int DEF_LAT_W    = 8;
endpackage

// File: rtl/sdram_stage_monitor_if.sv
// sdram_stage_monitor_if: request inputs and status outputs of the stage monitor.
interface sdram_stage_monitor_if
   import sdram_mon_pkg::*;
#(
   parameter int STATE_W  = DEF_STATE_W,
   parameter int N_STATES = DEF_N_STATES,
   parameter int LAT_W    = DEF_LAT_W
);
   logic                op_start;
   logic [1:0]          op_type;
   logic [STATE_W-1:0]  lft_state;
   logic                in_use;
   logic                done;
   logic                bad;
   logic                interrupted;
   logic                err_sticky;
   logic [2:0]          err_code;
   logic [N_STATES-1:0] events;
   logic [LAT_W-1:0]    last_latency;
   logic [15:0]         op_count;
   modport master (
      output op_start, op_type, lft_state,
      input  in_use, done, bad, interrupted, err_sticky, err_code, events, last_latency, op_count
   );
   modport slave (
      input  op_start, op_type, lft_state,
      output in_use, done, bad, interrupted, err_sticky, err_code, events, last_latency, op_count
   );
endinterface

// File: rtl/sdram_stage_monitor_window_order_check.sv
// window_order_check: in-order coverage of one inclusive stage window [LO,HI];
// a stage is out of order when it is missing while a later stage was already seen.
module window_order_check
   import sdram_mon_pkg::*;
#(
   parameter int N  = DEF_N_STATES,
   parameter int LO = DEF_WR_LO,
   parameter int HI = DEF_WR_HI
) (
   input  logic [N-1:0] events,
   output logic         order_bad,
   output logic         complete,
   output logic         started
);
   logic later;
   always_comb begin
      order_bad = 1'b0;
      later = 1'b0;
      for (int i = HI; i >= LO; i--) begin
         order_bad = order_bad | (!events[i] & later);
         later = later | events[i];
      end
      complete = &events[HI:LO];
      started = events[LO];
   end
endmodule

// File: rtl/sdram_stage_monitor.sv
// sdram_stage_monitor: tracks controller states visited during one host op, checks
// stage order, detects completion/refresh interruption/timeout and reports latency.
module sdram_stage_monitor
   import sdram_mon_pkg::*;
#(
   parameter int STATE_W  = DEF_STATE_W,
   parameter int N_STATES = DEF_N_STATES,
   parameter int WR_LO    = DEF_WR_LO,
   parameter int WR_HI    = DEF_WR_HI,
   parameter int RD_LO    = DEF_RD_LO,
   parameter int RD_HI    = DEF_RD_HI,
   parameter int RF_LO    = DEF_RF_LO,
   parameter int RF_HI    = DEF_RF_HI,
   parameter int TIMEOUT  = DEF_TIMEOUT,
   parameter int LAT_W    = DEF_LAT_W
) (
   input logic clk,
   input logic rst_n,
   sdram_stage_monitor_if.slave mon
);
   mon_state_t          state_q, state_d;
   op_t                 cur_op_q, cur_op_d;
   err_t                err_code_q, err_code_d;
   logic [LAT_W-1:0]    lat_ctr_q, lat_ctr_d, last_latency_q, last_latency_d;
   logic [N_STATES-1:0] events_q, events_d;
   logic [15:0]         op_count_q, op_count_d;
   logic                interrupted_q, interrupted_d, err_sticky_q, err_sticky_d;
   logic                wr_bad, wr_complete, wr_started, rd_bad, rd_complete, rd_started;
   logic                in_use, sel_bad, sel_complete, sel_started, rf_any, done, range_err, timeout;

   window_order_check #(.N(N_STATES), .LO(WR_LO), .HI(WR_HI)) u_wr (
      .events(events_q), .order_bad(wr_bad), .complete(wr_complete), .started(wr_started)
   );
   window_order_check #(.N(N_STATES), .LO(RD_LO), .HI(RD_HI)) u_rd (
      .events(events_q), .order_bad(rd_bad), .complete(rd_complete), .started(rd_started)
   );

   // REFR and IDLE have no stage window: they finish only through the refresh tail state
   always_comb begin
      in_use = state_q == S_TRACK;
      sel_bad = cur_op_q == WRITE ? wr_bad : cur_op_q == READ ? rd_bad : 1'b0;
      sel_complete = cur_op_q == WRITE ? wr_complete : cur_op_q == READ ? rd_complete : 1'b0;
      sel_started = cur_op_q == WRITE ? wr_started : cur_op_q == READ ? rd_started : 1'b0;
      rf_any = |events_q[RF_HI:RF_LO];
      done = in_use && (sel_complete || events_q[RF_HI]);
      range_err = in_use && !done && int'(mon.lft_state) >= N_STATES;
      timeout = in_use && !done && lat_ctr_q == LAT_W'(TIMEOUT);
   end

   always_comb begin
      state_d = state_q;
      cur_op_d = cur_op_q;
      lat_ctr_d = lat_ctr_q;
      events_d = events_q;
      last_latency_d = last_latency_q;
      op_count_d = op_count_q;
      interrupted_d = interrupted_q;
      err_sticky_d = err_sticky_q;
      err_code_d = err_code_q;
      if (!in_use) begin
         if (mon.op_start && mon.op_type != IDLE) begin
            state_d = S_TRACK;
            cur_op_d = op_t'(mon.op_type);
            lat_ctr_d = LAT_W'(1);
         end
      end else if (done) begin
         state_d = S_IDLE;
         events_d = '0;
         last_latency_d = lat_ctr_q;
         op_count_d = op_count_q + 16'd1;
         interrupted_d = 1'b0;
      end else if (timeout) begin
         state_d = S_IDLE;
         events_d = '0;
      end else begin
         for (int i = 0; i < N_STATES; i++)
            if (int'(mon.lft_state) == i) events_d[i] = 1'b1;
         lat_ctr_d = &lat_ctr_q ? lat_ctr_q : lat_ctr_q + 1'b1;
         interrupted_d = interrupted_q | (sel_started & !sel_complete & rf_any);
      end
      // only the first error cause is kept until reset
      if (!err_sticky_q && (sel_bad || range_err || timeout)) begin
         err_sticky_d = 1'b1;
         err_code_d = sel_bad ? ERR_ORDER : range_err ? ERR_RANGE : ERR_TIMEOUT;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cur_op_q <= IDLE;
         lat_ctr_q <= '0;
         events_q <= '0;
         last_latency_q <= '0;
         op_count_q <= '0;
         interrupted_q <= 1'b0;
         err_sticky_q <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         state_q <= state_d;
         cur_op_q <= cur_op_d;
         lat_ctr_q <= lat_ctr_d;
         events_q <= events_d;
         last_latency_q <= last_latency_d;
         op_count_q <= op_count_d;
         interrupted_q <= interrupted_d;
         err_sticky_q <= err_sticky_d;
         err_code_q <= err_code_d;
      end
   end

   assign mon.in_use = in_use;
   assign mon.done = done;
   assign mon.bad = sel_bad;
   assign mon.interrupted = interrupted_q;
   assign mon.err_sticky = err_sticky_q;
   assign mon.err_code = err_code_q;
   assign mon.events = events_q;
   assign mon.last_latency = last_latency_q;
   assign mon.op_count = op_count_q;
endmodule

// File: tb/tb_sdram_stage_monitor.sv
// tb_sdram_stage_monitor: scenario tasks for the SDRAM stage monitor, with a
// scoreboard of expected latency/count per completed operation.
module tb_sdram_stage_monitor;
   import sdram_mon_pkg::*;

   typedef struct {
      logic [7:0]  lat;
      logic [15:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   sdram_stage_monitor_if #(.STATE_W(5), .N_STATES(32), .LAT_W(8)) bus ();
   sdram_stage_monitor_if #(.STATE_W(4), .N_STATES(12), .LAT_W(5)) bus2 ();

   sdram_stage_monitor dut (.clk(clk), .rst_n(rst_n), .mon(bus));
   sdram_stage_monitor #(
      .STATE_W(4), .N_STATES(12), .WR_LO(8), .WR_HI(11), .RD_LO(5), .RD_HI(7),
      .RF_LO(1), .RF_HI(4), .TIMEOUT(20), .LAT_W(5)
   ) dut2 (.clk(clk), .rst_n(rst_n), .mon(bus2));

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.op_start = 1'b0; bus.op_type = 2'd0; bus.lft_state = '0;
      bus2.op_start = 1'b0; bus2.op_type = 2'd0; bus2.lft_state = '0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic start_op(input logic [1:0] t);
      bus.op_start = 1'b1;
      bus.op_type = t;
      tick();
      bus.op_start = 1'b0;
   endtask

   task automatic feed(input int s);
      bus.lft_state = 5'(s);
      tick();
   endtask

   task automatic wait_done(input string name);
      exp_t e;
      int k = 0;
      while (bus.done !== 1'b1 && k < 200) begin tick(); k++; end
      n_checks++;
      if (bus.done !== 1'b1) begin n_fail++; $display("FAIL %s_done: done never rose within 200 cycles", name); end
      else tick();
      if (sb.size() == 0) begin
         n_checks++; n_fail++; $display("FAIL %s_sb: scoreboard empty at completion", name);
      end else begin
         e = sb.pop_front();
         n_checks++;
         if (bus.last_latency !== e.lat) begin n_fail++; $display("FAIL %s_latency: got %0d want %0d", name, bus.last_latency, e.lat); end
         n_checks++;
         if (bus.op_count !== e.cnt) begin n_fail++; $display("FAIL %s_count: got %0d want %0d", name, bus.op_count, e.cnt); end
         n_checks++;
         if (bus.in_use !== 1'b0 || bus.events !== 32'd0) begin n_fail++; $display("FAIL %s_idle: in_use %b events %h want 0/0", name, bus.in_use, bus.events); end
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({bus.in_use, bus.done, bus.bad, bus.interrupted, bus.err_sticky} !== 5'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b want 00000", {bus.in_use, bus.done, bus.bad, bus.interrupted, bus.err_sticky});
      end
      n_checks++;
      if (bus.err_code !== 3'd0 || bus.events !== 32'd0) begin n_fail++; $display("FAIL reset_code_events: got %0d/%h want 0/0", bus.err_code, bus.events); end
      n_checks++;
      if (bus.last_latency !== 8'd0 || bus.op_count !== 16'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", bus.last_latency, bus.op_count); end
   endtask

   task automatic test_write();
      int seq[$];
      do_reset();
      start_op(2'd0);
      n_checks++;
      if (bus.in_use !== 1'b0) begin n_fail++; $display("FAIL idle_op_ignored: in_use %b want 0", bus.in_use); end
      sb.push_back('{lat: 8'd5, cnt: 16'd1});
      start_op(2'd1);
      n_checks++;
      if (bus.in_use !== 1'b1) begin n_fail++; $display("FAIL wr_in_use: got %b want 1", bus.in_use); end
      seq = '{24, 25, 26, 27};
      foreach (seq[i]) begin
         feed(seq[i]);
         n_checks++;
         if (bus.bad !== 1'b0) begin n_fail++; $display("FAIL wr_bad_%0d: got %b want 0", seq[i], bus.bad); end
      end
      n_checks++;
      if (bus.done !== 1'b1 || bus.events !== 32'h0f00_0000) begin n_fail++; $display("FAIL wr_done_events: done %b events %h want 1/0f000000", bus.done, bus.events); end
      wait_done("wr");
      // back to back, with a stray op_start mid-operation that must be ignored
      sb.push_back('{lat: 8'd5, cnt: 16'd2});
      start_op(2'd1);
      feed(24);
      bus.op_start = 1'b1; bus.op_type = 2'd2;
      feed(25);
      bus.op_start = 1'b0;
      feed(26);
      feed(27);
      wait_done("b2b");
      n_checks++;
      if (bus.err_sticky !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b want 0", bus.err_sticky); end
   endtask

   task automatic test_read_order();
      int k = 0;
      do_reset();
      start_op(2'd2);
      feed(16);
      n_checks++;
      if (bus.bad !== 1'b0) begin n_fail++; $display("FAIL rd_bad_16: got %b want 0", bus.bad); end
      feed(18);
      n_checks++;
      if (bus.bad !== 1'b1 || bus.err_sticky !== 1'b0) begin n_fail++; $display("FAIL rd_bad_18: bad %b err %b want 1/0", bus.bad, bus.err_sticky); end
      tick();
      n_checks++;
      if (bus.err_sticky !== 1'b1 || bus.err_code !== 3'd1) begin n_fail++; $display("FAIL rd_order_err: err %b code %0d want 1/1", bus.err_sticky, bus.err_code); end
      while (bus.in_use === 1'b1 && k < 100) begin tick(); k++; end
      n_checks++;
      if (bus.in_use !== 1'b0 || bus.events !== 32'd0 || bus.err_code !== 3'd1) begin
         n_fail++; $display("FAIL rd_timeout_keeps_order: in_use %b events %h code %0d want 0/0/1", bus.in_use, bus.events, bus.err_code);
      end
   endtask

   task automatic test_interrupt();
      do_reset();
      sb.push_back('{lat: 8'd6, cnt: 16'd1});
      start_op(2'd2);
      feed(16);
      feed(17);
      feed(2);
      n_checks++;
      if (bus.events !== 32'h0003_0004 || bus.interrupted !== 1'b0) begin n_fail++; $display("FAIL int_events: events %h int %b want 00030004/0", bus.events, bus.interrupted); end
      feed(3);
      n_checks++;
      if (bus.interrupted !== 1'b1) begin n_fail++; $display("FAIL int_set: got %b want 1", bus.interrupted); end
      feed(4);
      n_checks++;
      if (bus.done !== 1'b1) begin n_fail++; $display("FAIL int_done_rf: got %b want 1", bus.done); end
      wait_done("int");
      n_checks++;
      if (bus.interrupted !== 1'b0 || bus.err_sticky !== 1'b0) begin n_fail++; $display("FAIL int_clear: int %b err %b want 0/0", bus.interrupted, bus.err_sticky); end
   endtask

   task automatic test_timeout();
      do_reset();
      start_op(2'd1);
      bus.lft_state = 5'd0;
      repeat (62) tick();
      n_checks++;
      if (bus.in_use !== 1'b1 || bus.err_sticky !== 1'b0 || bus.events !== 32'd1) begin
         n_fail++; $display("FAIL to_before: in_use %b err %b events %h want 1/0/1", bus.in_use, bus.err_sticky, bus.events);
      end
      tick();
      n_checks++;
      if (bus.in_use !== 1'b0 || bus.err_sticky !== 1'b1 || bus.err_code !== 3'd2 || bus.events !== 32'd0) begin
         n_fail++; $display("FAIL to_fire: in_use %b err %b code %0d events %h want 0/1/2/0", bus.in_use, bus.err_sticky, bus.err_code, bus.events);
      end
   endtask

   task automatic test_done_beats_timeout();
      do_reset();
      sb.push_back('{lat: 8'd63, cnt: 16'd1});
      start_op(2'd1);
      bus.lft_state = 5'd0;
      repeat (58) tick();
      feed(24);
      feed(25);
      feed(26);
      feed(27);
      wait_done("edge63");
      n_checks++;
      if (bus.err_sticky !== 1'b0 || bus.err_code !== 3'd0) begin n_fail++; $display("FAIL edge63_err: err %b code %0d want 0/0", bus.err_sticky, bus.err_code); end
   endtask

   task automatic test_reset_mid_op();
      do_reset();
      start_op(2'd1);
      feed(24);
      n_checks++;
      if (bus.events !== 32'h0100_0000) begin n_fail++; $display("FAIL rst_events: got %h want 01000000", bus.events); end
      feed(26);
      tick();
      n_checks++;
      if (bus.err_sticky !== 1'b1 || bus.err_code !== 3'd1) begin n_fail++; $display("FAIL rst_pre_err: err %b code %0d want 1/1", bus.err_sticky, bus.err_code); end
      rst_n = 1'b0;
      tick();
      n_checks++;
      if ({bus.in_use, bus.done, bus.bad, bus.interrupted, bus.err_sticky} !== 5'b0 || bus.err_code !== 3'd0 || bus.events !== 32'd0) begin
         n_fail++; $display("FAIL rst_mid_op: flags %b code %0d events %h want 0/0/0", {bus.in_use, bus.done, bus.bad, bus.interrupted, bus.err_sticky}, bus.err_code, bus.events);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_sweep();
      do_reset();
      bus2.op_start = 1'b1; bus2.op_type = 2'd1;
      tick();
      bus2.op_start = 1'b0;
      bus2.lft_state = 4'd8; tick();
      bus2.lft_state = 4'd13; tick();
      n_checks++;
      if (bus2.err_sticky !== 1'b1 || bus2.err_code !== 3'd3 || bus2.events !== 12'h100) begin
         n_fail++; $display("FAIL sweep_range: err %b code %0d events %h want 1/3/100", bus2.err_sticky, bus2.err_code, bus2.events);
      end
      bus2.lft_state = 4'd9; tick();
      bus2.lft_state = 4'd10; tick();
      bus2.lft_state = 4'd11; tick();
      n_checks++;
      if (bus2.done !== 1'b1) begin n_fail++; $display("FAIL sweep_done: got %b want 1", bus2.done); end
      tick();
      n_checks++;
      if (bus2.last_latency !== 5'd6 || bus2.op_count !== 16'd1 || bus2.in_use !== 1'b0) begin
         n_fail++; $display("FAIL sweep_complete: lat %0d count %0d in_use %b want 6/1/0", bus2.last_latency, bus2.op_count, bus2.in_use);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_order();
      test_interrupt();
      test_timeout();
      test_done_beats_timeout();
      test_reset_mid_op();
      test_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
